// File: rtl/coriolis_arb_pkg.sv
// Shared constants and helpers for the coriolis FP-adder sharing arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package coriolis_arb_pkg;

  // Pipeline depth of FPAdd_8_23_F300_uid2 as generated for this kernel.
  localparam int ADD_LAT_DEFAULT = 8;

  // FloPoCo exception field value for an ordinary (finite, non-zero) number.
  localparam logic [1:0] FP_EXC_NORMAL = 2'b01;

  // Widest requester count supported by the helpers below.
  localparam int MAX_REQ = 16;

  // One-hot decode of a requester index; callers slice down to their width.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

  // Ceiling log2 that never returns 0, so a 1-wide index is still legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/coriolis_rr_arbiter.sv
// Round-robin requester select with a rotating priority pointer.
// Latency: grant is combinational in the request cycle; pointer updates on the edge.
// Backpressure: en=0 suppresses every grant and freezes the pointer.
module coriolis_rr_arbiter
  import coriolis_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = clog2_min1(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            grant_any,
  output logic [TAGW-1:0] grant_idx
);

  logic [TAGW-1:0] ptr_q, ptr_d;
  logic            found;
  logic [TAGW-1:0] idx;
  logic [TAGW-1:0] cand;
  logic [MAX_REQ-1:0] oh;
  int              j;

  // Search from the pointer upward, wrapping, and take the first active request.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = TAGW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  // Qualify the grant with the enable and advance the pointer past the winner.
  always_comb begin
    grant_any = en & found;
    grant_idx = idx;
    oh        = onehot(4'(idx));
    gnt       = grant_any ? oh[NREQ-1:0] : '0;
    ptr_d     = ptr_q;
    if (grant_any) begin
      ptr_d = (idx == TAGW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Pointer register; reset starts the rotation at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/coriolis_fpadd_share_arb.sv
// Time-shares one pipelined FP adder among NREQ streams, routing results back by tag.
// Latency: ADD_LAT cycles from accept to res_valid, plus any freeze cycles in between.
// Backpressure: an unready owner of the tail result freezes the adder, the tag pipe and all grants.
module coriolis_fpadd_share_arb
  import coriolis_arb_pkg::*;
#(
  parameter int STREAMW = 34,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = ADD_LAT_DEFAULT,
  parameter int TAGW    = clog2_min1(NREQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ*STREAMW-1:0]             req_x,
  input  logic [NREQ*STREAMW-1:0]             req_y,
  output logic [STREAMW-1:0]                  add_x,
  output logic [STREAMW-1:0]                  add_y,
  output logic                                add_stall,
  input  logic [STREAMW-1:0]                  add_r,
  output logic [NREQ-1:0]                     res_valid,
  input  logic [NREQ-1:0]                     res_ready,
  output logic [STREAMW-1:0]                  res_data,
  output logic [TAGW+$clog2(ADD_LAT+1)-1:0]   inflight
);

  localparam int CNTW = TAGW + $clog2(ADD_LAT + 1);
  localparam int TAGP = 1 << TAGW;

  // Tag pipeline: one {vld, tag} per adder stage, tail aligned with add_r.
  logic [ADD_LAT-1:0] vld_q, vld_d;
  logic [TAGW-1:0]    tag_q [ADD_LAT];
  logic [TAGW-1:0]    tag_d [ADD_LAT];

  logic [STREAMW-1:0] add_x_q, add_x_d;
  logic [STREAMW-1:0] add_y_q, add_y_d;
  logic [CNTW-1:0]    inflight_q, inflight_d;

  logic               tail_vld;
  logic [TAGW-1:0]    tail_tag;
  logic [TAGP-1:0]    res_rdy_ext;
  logic               freeze;
  logic               arb_en;
  logic               consume;
  logic               grant_any;
  logic [TAGW-1:0]    grant_idx;
  logic [NREQ-1:0]    grant_oh;
  logic [MAX_REQ-1:0] tail_oh;

  // Widen res_ready to the full tag range so any tag value indexes safely.
  always_comb begin
    res_rdy_ext             = '0;
    res_rdy_ext[NREQ-1:0]   = res_ready;
  end

  assign tail_vld = vld_q[ADD_LAT-1];
  assign tail_tag = tag_q[ADD_LAT-1];

  // Freeze whenever the result at the tail cannot be delivered to its owner.
  always_comb begin
    freeze  = tail_vld & ~res_rdy_ext[tail_tag];
    consume = tail_vld &  res_rdy_ext[tail_tag];
    arb_en  = ~freeze & ~rst;
  end

  coriolis_rr_arbiter #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req       (req_valid),
    .gnt       (grant_oh),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant_oh;
  assign add_stall = freeze;
  assign res_data  = add_r;
  assign inflight  = inflight_q;

  // Route the winner's operands to the adder; bubbles repeat the last operands.
  always_comb begin
    add_x_d = add_x_q;
    add_y_d = add_y_q;
    if (grant_any) begin
      add_x_d = req_x[int'(grant_idx)*STREAMW +: STREAMW];
      add_y_d = req_y[int'(grant_idx)*STREAMW +: STREAMW];
    end
    add_x = add_x_d;
    add_y = add_y_d;
  end

  // Result routing: only the tail's owner sees a valid.
  always_comb begin
    tail_oh   = onehot(4'(tail_tag));
    res_valid = tail_vld ? tail_oh[NREQ-1:0] : '0;
  end

  // Shift the tag pipeline in lockstep with the adder unless frozen.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (!freeze) begin
      vld_d[0] = grant_any;
      tag_d[0] = grant_idx;
      for (int k = 1; k < ADD_LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  // Occupancy: accept and consume in the same cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    case ({grant_any, consume})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers; reset drops every in-flight op and its eventual result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      for (int k = 0; k < ADD_LAT; k++) tag_q[k] <= '0;
      add_x_q    <= '0;
      add_y_q    <= '0;
      inflight_q <= '0;
    end else begin
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      add_x_q    <= add_x_d;
      add_y_q    <= add_y_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_coriolis_fpadd_share_arb.sv
// Randomized bench for the shared FP-adder arbiter with a queue-based reference model.
// Latency: models an ADD_LAT-deep adder that freezes on add_stall.
// Backpressure: drives res_ready patterns, including a targeted 5-cycle stall on requester 1.
module tb_coriolis_fpadd_share_arb;
  import coriolis_arb_pkg::*;

  localparam int STREAMW = 34;
  localparam int NREQ    = 4;
  localparam int ADD_LAT = 8;
  localparam int TAGW    = 2;
  localparam int CNTW    = TAGW + $clog2(ADD_LAT + 1);

  logic                      clk;
  logic                      rst;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*STREAMW-1:0]   req_x;
  logic [NREQ*STREAMW-1:0]   req_y;
  logic [STREAMW-1:0]        add_x;
  logic [STREAMW-1:0]        add_y;
  logic                      add_stall;
  logic [STREAMW-1:0]        add_r;
  logic [NREQ-1:0]           res_valid;
  logic [NREQ-1:0]           res_ready;
  logic [STREAMW-1:0]        res_data;
  logic [CNTW-1:0]           inflight;

  coriolis_fpadd_share_arb #(
    .STREAMW (STREAMW),
    .NREQ    (NREQ),
    .ADD_LAT (ADD_LAT),
    .TAGW    (TAGW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_stall (add_stall),
    .add_r     (add_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact single -> double widening for normal numbers.
  function automatic real s2d(input logic [31:0] a);
    return $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0});
  endfunction

  // Double -> single with round-to-nearest-even (results stay in normal range here).
  function automatic logic [31:0] d2s(input real r);
    logic [63:0] d;
    logic [31:0] s;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'b0};
    s = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) s = s + 32'd1;
    return s;
  endfunction

  function automatic logic [33:0] fp_add(input logic [33:0] a, input logic [33:0] b);
    logic [31:0] s;
    s = d2s(s2d(a[31:0]) + s2d(b[31:0]));
    return {(s[30:0] == 31'd0) ? 2'b00 : FP_EXC_NORMAL, s};
  endfunction

  function automatic logic [33:0] rand_op();
    logic [7:0] e;
    e = 8'($urandom_range(120, 135));
    return {FP_EXC_NORMAL, 1'($urandom), e, 23'($urandom)};
  endfunction

  // Behavioural adder: ADD_LAT deep, frozen by add_stall.
  logic [33:0] apipe [ADD_LAT];
  always @(posedge clk) begin
    if (!add_stall) begin
      apipe[0] <= fp_add(add_x, add_y);
      for (int k = 1; k < ADD_LAT; k++) apipe[k] <= apipe[k-1];
    end
  end
  assign add_r = apipe[ADD_LAT-1];

  // Reference model: ops in issue order with the count of unfrozen edges they have seen.
  typedef struct {
    int          tag;
    logic [33:0] x;
    logic [33:0] y;
    int          age;
  } op_t;
  op_t q[$];
  int  ptr;
  int  n_vec;
  int  n_err;
  int  stall_seen;
  int  rv_seen;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*STREAMW +: STREAMW] = rand_op();
      req_y[i*STREAMW +: STREAMW] = rand_op();
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    bit              in_rst;
    bit              mat;
    bit              frz;
    int              g;
    int              j;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rv;
    op_t             n;
    in_rst = 1'b0;
    mat    = 1'b0;
    frz    = 1'b0;
    g      = -1;
    #3;
    if (rst) begin
      in_rst = 1'b1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_add_stall", 64'(add_stall), 64'd0);
      check("rst_inflight",  64'(inflight),  64'd0);
      check("rst_add_x",     64'(add_x),     64'd0);
      check("rst_add_y",     64'(add_y),     64'd0);
      q.delete();
      ptr = 0;
    end else begin
      mat = (q.size() > 0) && (q[0].age == ADD_LAT);
      frz = mat && !res_ready[q[0].tag];
      exp_rv = mat ? NREQ'(1 << q[0].tag) : '0;
      if (!frz) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (ptr + k) % NREQ;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("res_valid", 64'(res_valid), 64'(exp_rv));
      check("add_stall", 64'(add_stall), 64'(frz));
      check("inflight",  64'(inflight),  64'(q.size()));
      if (mat) check("res_data", 64'(res_data), 64'(fp_add(q[0].x, q[0].y)));
      if (g >= 0) begin
        check("add_x", 64'(add_x), 64'(req_x[g*STREAMW +: STREAMW]));
        check("add_y", 64'(add_y), 64'(req_y[g*STREAMW +: STREAMW]));
      end
      if (add_stall) stall_seen++;
      if (res_valid != '0) rv_seen++;
    end
    @(posedge clk);
    if (!in_rst && !frz) begin
      if (mat) void'(q.pop_front());
      if (g >= 0) begin
        n.tag = g;
        n.x   = req_x[g*STREAMW +: STREAMW];
        n.y   = req_y[g*STREAMW +: STREAMW];
        n.age = 0;
        q.push_back(n);
        ptr = (g + 1) % NREQ;
      end
      foreach (q[i]) q[i].age++;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp_left;
    n_vec = 0; n_err = 0; ptr = 0; stall_seen = 0; rv_seen = 0;
    rst = 1'b1; req_valid = '0; res_ready = '1; req_x = '0; req_y = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    // Idle after reset.
    repeat (20) begin randomize_ops(); cycle(); end

    // Single op on requester 2: 1.0 + 2.0.
    req_valid = 4'b0100;
    req_x[2*STREAMW +: STREAMW] = 34'h1_3F800000;
    req_y[2*STREAMW +: STREAMW] = 34'h1_40000000;
    cycle();
    req_valid = '0;
    check("single_inflight", 64'(inflight), 64'd1);
    repeat (7) cycle();
    check("single_res_valid", 64'(res_valid), 64'h4);
    check("single_res_data",  64'(res_data),  64'h1_40400000);
    repeat (3) cycle();
    check("single_drained", 64'(inflight), 64'd0);

    // All requesters continuously valid.
    req_valid = 4'hf;
    repeat (24) begin randomize_ops(); cycle(); end

    // Hold off requester 1's result for exactly 5 cycles while it sits at the tail.
    bp_left = 5;
    stall_seen = 0;
    for (int c = 0; c < 40; c++) begin
      res_ready = '1;
      if (bp_left > 0 && q.size() > 0 && q[0].age == ADD_LAT && q[0].tag == 1) begin
        res_ready[1] = 1'b0;
        bp_left--;
      end
      randomize_ops();
      cycle();
    end
    res_ready = '1;
    check("bp_applied", 64'(bp_left), 64'd0);
    check("bp_stall_cycles", 64'(stall_seen), 64'd5);

    // Pointer wrap and skip: last grant 3, then only 3 and 0 requesting.
    req_valid = '0;
    repeat (12) cycle();
    req_valid = 4'b1000;
    randomize_ops();
    cycle();
    req_valid = 4'b1001;
    repeat (10) begin randomize_ops(); cycle(); end

    // Random traffic with random back-pressure.
    repeat (400) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) res_ready[i] = ($urandom_range(0, 3) != 0);
      randomize_ops();
      cycle();
    end

    // Mid-flight reset with five ops in the pipe.
    res_ready = '1;
    req_valid = '0;
    repeat (ADD_LAT + 4) cycle();
    req_valid = 4'hf;
    repeat (5) begin randomize_ops(); cycle(); end
    req_valid = '0;
    check("pre_rst_inflight", 64'(inflight), 64'd5);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    rv_seen = 0;
    repeat (10) cycle();
    check("post_rst_quiet", 64'(rv_seen), 64'd0);
    req_valid = 4'b0010;
    randomize_ops();
    cycle();
    req_valid = '0;
    repeat (12) cycle();
    check("post_rst_one_result", 64'(rv_seen), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coriolis_fpadd_share_arb.md
Name: coriolis_fpadd_share_arb

Overview:
- Round-robin arbiter that time-shares one pipelined FP adder (FPAdd_8_23_F300_uid2, latency ADD_LAT) among NREQ independent operand streams in the coriolis kernel.
- Issues at most one operation per cycle. Tags each issued op with its requester index and returns each result to its owner's result channel.
- Propagates result back-pressure into a global freeze of the adder and the tag pipeline.
- Sits between kernel stream producers and the shared adder instance; the adder itself stays outside this block.

Parameters:
- STREAMW, 34, operand/result width (FloPoCo format: 2-bit exception field + IEEE single).
- NREQ, 4, number of requesters (2..16).
- ADD_LAT, 8, adder pipeline depth in cycles (stall=0 cycles).
- TAGW, $clog2(NREQ), requester-index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant/accept.
- req_x  in  NREQ*STREAMW  packed X operands; requester i at [i*STREAMW +: STREAMW].
- req_y  in  NREQ*STREAMW  packed Y operands, same packing.
- add_x  out  STREAMW  X operand to the adder.
- add_y  out  STREAMW  Y operand to the adder.
- add_stall  out  1  freeze for the adder pipeline.
- add_r  in  STREAMW  adder result.
- res_valid  out  NREQ  one-hot result valid.
- res_ready  in  NREQ  per-requester result ready.
- res_data  out  STREAMW  result, shared by all requesters; qualified by res_valid.
- inflight  out  TAGW+$clog2(ADD_LAT+1)  count of ops currently in the pipeline.

Behaviour:
- Reset: clk and rst as above. While rst=1, asynchronously clear the tag pipeline valids, the RR pointer (→0) and inflight (→0). Outputs while and after reset: req_ready=0, res_valid=0, add_x=add_y=0, add_stall=0. A reset mid-operation discards all in-flight ops; no res_valid may appear for them.
- Tag pipeline: ADD_LAT stages of {vld, tag[TAGW-1:0]}. Stage ADD_LAT-1 (the tail) aligns with add_r.
- Freeze condition: freeze = tail.vld & ~res_ready[tail.tag].
  - add_stall = freeze.
  - While frozen, the tag pipeline holds and no grant is issued.
- Grant (same cycle, combinational):
  - If ~freeze, choose the first i with req_valid[i]=1, searching i = ptr, ptr+1, …, wrapping modulo NREQ.
  - req_ready = onehot(i); no grant → req_ready=0.
  - req_ready never depends on req_valid of other requesters beyond RR selection.
  - add_x/add_y = the granted requester's operands. With no grant, hold the previous values; vld=0 marks the bubble.
- Advance, on posedge when ~freeze:
  - Shift the tag pipeline; stage0 ← {grant_any, grant_idx}.
  - If grant_any, ptr ← grant_idx+1 (wraps NREQ-1→0).
  - ptr is unchanged when there is no grant or when frozen.
- Result channel:
  - res_valid = tail.vld ? onehot(tail.tag) : 0.
  - res_data = add_r, passed straight through.
  - Results return in issue order.
- Latency: an op accepted at cycle t gives res_valid at t+ADD_LAT, plus the number of freeze cycles in between.
- Throughput: 1 op/cycle with no back-pressure.
- inflight: +1 on an accepted op, −1 on a consumed result (tail.vld & res_ready[tail.tag] & ~freeze). If both happen in the same cycle, it is unchanged. Bounded to 0..ADD_LAT.
- Fairness: a requester holding req_valid=1 is granted within NREQ unfrozen cycles.

Decomposition:
- Shared package coriolis_arb_pkg: ADD_LAT default, FloPoCo exception constant 2'b01, and a onehot/clog2 helper function.
- One sub-module: coriolis_rr_arbiter (NREQ-wide round-robin with pointer, enable, grant_any, grant_idx). The tag pipeline and freeze logic stay in the top.

Test Plan:
- Reset then idle: rst pulse, all req_valid=0 → req_ready=0, res_valid=0, inflight=0, add_stall=0 for 20 cycles.
- Single op: req 2 issues X=34'h1_3F800000 (1.0), Y=34'h1_40000000 (2.0) at cycle t → req_ready[2]=1 at t; res_valid=4'b0100 with res_data=34'h1_40400000 (3.0) at t+8; inflight goes 1 then 0.
- All four requesters continuously valid → grants rotate 0,1,2,3,0,… one per cycle. After the first 8 cycles, res_valid rotates in the same order, and each result equals its own operands' sum.
- Back-pressure: res_ready[1]=0 for 5 cycles while tail.tag=1 → add_stall=1 and req_ready=0 for exactly 5 cycles, tag pipeline frozen. The result releases intact on the cycle res_ready[1] rises, with no lost or duplicated results.
- Pointer wrap/skip: only req 3 and req 0 valid, last grant was 3 → next grant is 0, then 3. ptr never stalls on idle requesters.
- Mid-flight reset: assert rst with inflight=5 → res_valid=0 for the next 10 cycles after release. The next accepted op produces exactly one result at its own t+8.
